// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, ROM chip enable/address, and the
// IF/ID pipeline register feeding decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic        ce_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_adel_o
);

  logic adel;
  logic unused_stall;

  // Bits 5:3 belong to later stages.
  assign unused_stall = ^stall[5:3];

  assign adel = ce_o & (pc_o[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_o <= 1'b0;
    end else begin
      ce_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_o <= '0;
    end else if (!ce_o) begin
      pc_o <= RESET_PC;
    end else if (flush) begin
      pc_o <= new_pc;
    end else if (stall[0]) begin
      pc_o <= pc_o;
    end else if (branch_flag_i) begin
      pc_o <= branch_target_i;
    end else begin
      pc_o <= pc_o + 32'd4;
    end
  end

  // A misaligned fetch is turned into a nop tagged with the adel flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_o   <= '0;
      id_inst_o <= '0;
      id_adel_o <= 1'b0;
    end else if (flush || (stall[1] && !stall[2])) begin
      id_pc_o   <= '0;
      id_inst_o <= '0;
      id_adel_o <= 1'b0;
    end else if (!stall[1]) begin
      id_pc_o   <= pc_o;
      id_inst_o <= adel ? '0 : inst_i;
      id_adel_o <= adel;
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core: holds the program counter, drives the chip-enable and byte address of the instruction ROM, and registers the returned instruction word into the IF/ID pipeline register. The ROM is combinational, so the instruction for `pc_o` is valid in the same cycle. This block sits between the control/ID stage, which supplies stall, branch and flush requests, and the decode stage, which consumes `id_pc_o` and `id_inst_o`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on the first enabled cycle after reset.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  6  pipeline stall vector from the control unit. Bit 0 = PC, bit 1 = IF, bit 2 = ID. Bits 5:3 are ignored here.
- `flush`  in  1  exception flush; highest priority.
- `new_pc`  in  32  exception handler address, used with `flush`.
- `branch_flag_i`  in  1  taken branch or jump resolved in ID.
- `branch_target_i`  in  32  branch or jump destination.
- `inst_i`  in  32  instruction word returned by the ROM.
- `pc_o`  out  32  byte address to the ROM.
- `ce_o`  out  1  ROM chip enable.
- `id_pc_o`  out  32  registered PC for decode.
- `id_inst_o`  out  32  registered instruction for decode.
- `id_adel_o`  out  1  registered fetch-address-misaligned flag.

## Operation
- **Reset.** While `rst`=1, or asynchronously on its assertion:
  - `ce_o`=0, `pc_o`=0.
  - `id_pc_o`=0, `id_inst_o`=0, `id_adel_o`=0.
- **Enable.** `ce_o` goes to 1 on the first rising edge after reset deasserts and stays 1 until the next reset.
- **PC register.**
  - On an edge where `ce_o` was 0, the PC loads `RESET_PC`.
  - On an edge where `ce_o` was 1, the next PC is chosen by priority:
    1. `flush` → `new_pc`.
    2. `stall[0]` → hold.
    3. `branch_flag_i` → `branch_target_i`.
    4. Otherwise `pc_o`+4, 32-bit, wrapping (32'hFFFF_FFFC+4 = 0).
  - `flush` overrides `stall[0]`.
- **Delay slot.** When `branch_flag_i` is asserted, the instruction currently being fetched is the delay slot. It is passed to ID normally and is not squashed.
- **Misalignment.**
  - `adel` = `ce_o` & (`pc_o[1:0]` != 0).
  - When `adel`=1, the instruction captured into IF/ID is forced to 0 (nop) and `id_adel_o`=1.
  - The PC is not corrected; the exception unit redirects it via `flush`.
- **IF/ID register**, at each edge, by priority:
  1. `flush` → `id_pc_o`=0, `id_inst_o`=0, `id_adel_o`=0.
  2. `stall[1]`=1 and `stall[2]`=0 → insert a bubble (all three cleared).
  3. `stall[1]`=0 → capture `pc_o`, `inst_i` (or 0 if `adel`), and `adel`.
  4. Otherwise hold.
- **ROM disabled.** While `ce_o`=0 the ROM returns 0, so a capture loads a nop.

## Timing
- The ROM address-to-instruction path is combinational. The fetch-to-decode latency is one cycle: the instruction at `pc_o` in cycle N appears on `id_inst_o` in cycle N+1.
- First fetch sequence after reset release:
  - Edge 1: `ce_o`=1, `pc_o`=`RESET_PC`.
  - Edge 2: `pc_o`=`RESET_PC`+4, and `id_inst_o` = instruction at `RESET_PC`.
- Branch redirect costs no bubble. `branch_flag_i` in cycle N gives `pc_o`=target in N+1, while the delay slot fetched in N is in ID in N+1.
- `flush` takes effect on the same edge for both the PC and IF/ID; there is no residual state.
- A reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge. Any in-flight branch or flush is discarded.
- Simultaneous `flush`, `branch_flag_i` and `stall`: `flush` wins for both registers.
- Simultaneous `stall[0]`=1 and `branch_flag_i`=1: the PC holds and the branch is lost. The control unit must keep `branch_flag_i` asserted for as long as ID is stalled.

## Test plan
- **Reset and sequential fetch.**
  - Stimulus: `rst` high for 3 cycles then low, no stalls, ROM returning word = address.
  - Required: `ce_o`=0 and `pc_o`=0 during reset. Then `pc_o` = 0, 4, 8, 12 on successive cycles, with `id_pc_o` and `id_inst_o` trailing by one cycle.
- **Branch with delay slot.**
  - Stimulus: at `pc_o`=8, pulse `branch_flag_i` with target 32'h40.
  - Required: `pc_o` sequence 8, 0x40, 0x44. Decode sees 8, then 0x40; the delay slot at 8 is not squashed.
- **Stall behaviour.**
  - Stimulus: `stall`=6'b000111 for 2 cycles at `pc_o`=0x10.
  - Required: `pc_o`, `id_pc_o` and `id_inst_o` all hold.
  - Stimulus: then `stall`=6'b000011 for 1 cycle.
  - Required: `id_inst_o` becomes 0 (bubble) while `pc_o` stays 0x10.
- **Flush priority.**
  - Stimulus: `flush`=1, `new_pc`=32'h20, together with `stall`=6'b000111 and `branch_flag_i`=1.
  - Required: next cycle `pc_o`=0x20, `id_inst_o`=0, `id_pc_o`=0.
- **Misaligned target.**
  - Stimulus: branch to 32'h42.
  - Required: the cycle after `pc_o`=0x42, `id_adel_o`=1 and `id_inst_o`=0.
- **Asynchronous reset and wrap-around.**
  - Stimulus: assert `rst` between clock edges mid-run.
  - Required: all outputs go to 0 before the next edge.
  - Stimulus: separately, `flush` to `new_pc`=32'hFFFF_FFFC.
  - Required: `pc_o` wraps to 0 on the following cycle.
